// File: rtl/toggle_cover_collector.sv
// Sticky toggle-cover collector: latches hit points and serialises newly hit
// points onto a valid/ready report channel. Optional per-point hit counters under TOGGLE_COVER_COUNT_EN.
module toggle_cover_collector #(
  parameter int WIDTH       = 130,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = 8744,
  parameter int IDX_W       = 32,
  parameter int CNT_W       = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  output logic                       cover_valid,
  input  logic                       cover_ready,
  output logic [IDX_W-1:0]           cover_index,
  output logic [CNT_W-1:0]           cover_count,
  output logic [$clog2(WIDTH+1)-1:0] covered_count,
  output logic                       all_covered
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, SCAN, PRESENT} state_t;

  state_t           state;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] set_mask;
  logic [WIDTH-1:0] clr_mask;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    ptr_inc;
  logic [CW-1:0]    pop;
  logic             handshake;

  // COVER_TOTAL is only meaningful to the sink; it is still checked for consistency here
  if (WIDTH < 1 || WIDTH > 4096 || COVER_TOTAL < COVER_INDEX + WIDTH) begin : g_param_check
    $error("toggle_cover_collector: illegal WIDTH / COVER_INDEX / COVER_TOTAL");
  end

  assign handshake = cover_valid & cover_ready;
  assign ptr_inc   = (ptr == PW'(WIDTH-1)) ? '0 : ptr + PW'(1);

  always_comb begin
    clr_mask = '0;
    if (handshake) clr_mask[ptr] = 1'b1;
  end

`ifdef TOGGLE_COVER_COUNT_EN
  logic [CNT_W-1:0] cnt [WIDTH];

  assign set_mask    = valid;
  assign cover_count = cover_valid ? cnt[ptr] : '0;

  // a re-hit in the handshake cycle restarts the count at 1 rather than 0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (handshake && ptr == PW'(i))
          cnt[i] <= valid[i] ? CNT_W'(1) : '0;
        else if (valid[i] && cnt[i] != '1)
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end
`else
  assign set_mask    = valid & ~hit;
  assign cover_count = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit     <= '0;
      pending <= '0;
    end else if (clear) begin
      hit     <= '0;
      pending <= '0;
    end else begin
      hit     <= hit | valid;
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + CW'(hit[i]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      covered_count <= '0;
    else if (clear)  covered_count <= '0;
    else             covered_count <= pop;
  end

  assign all_covered = (covered_count == CW'(WIDTH));

  // scanner; ptr holds in IDLE so the next search resumes where the last one stopped
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      cover_valid <= 1'b0;
      cover_index <= '0;
    end else if (clear) begin
      state       <= IDLE;
      ptr         <= '0;
      cover_valid <= 1'b0;
      cover_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) state <= SCAN;
        end
        SCAN: begin
          if (pending[ptr]) begin
            state       <= PRESENT;
            cover_valid <= 1'b1;
            cover_index <= IDX_W'(COVER_INDEX) + IDX_W'(ptr);
          end else if (!(|pending)) begin
            state <= IDLE;
          end else begin
            ptr <= ptr_inc;
          end
        end
        PRESENT: begin
          if (handshake) begin
            cover_valid <= 1'b0;
            ptr         <= ptr_inc;
            state       <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
